// File: rtl/pipe_stage_reg_if.sv
// Bus between two pipeline stages and the stage register that separates them.
// Carries the hazard/exception controls (req_i, flush_i, stall_i), the incoming
// instruction slot (in_*) and the registered slot seen by the next stage (out_*).
// master: upstream side (drives controls and in_*, observes out_*).
// slave : the pipe_stage_reg instance (consumes controls and in_*, drives out_*).
interface pipe_stage_reg_if #(
  parameter int unsigned N_DATA = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned TNEW_W = 3,
  parameter int unsigned EXC_W  = 5
);
  localparam int unsigned PAYLOAD_W = N_DATA * DATA_W;
  localparam int unsigned WR_W      = 5;

  logic                 req_i;
  logic                 flush_i;
  logic                 stall_i;

  logic                 in_valid;
  logic [DATA_W-1:0]    in_pc;
  logic                 in_bd;
  logic [EXC_W-1:0]     in_exccode;
  logic [WR_W-1:0]      in_wr;
  logic                 in_regwrite;
  logic [CTRL_W-1:0]    in_ctrl;
  logic [TNEW_W-1:0]    in_tnew;
  logic [PAYLOAD_W-1:0] in_data;

  logic                 out_valid;
  logic [DATA_W-1:0]    out_pc;
  logic                 out_bd;
  logic [EXC_W-1:0]     out_exccode;
  logic [WR_W-1:0]      out_wr;
  logic                 out_regwrite;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [TNEW_W-1:0]    out_tnew;
  logic [PAYLOAD_W-1:0] out_data;

  modport master (
    output req_i, flush_i, stall_i,
    output in_valid, in_pc, in_bd, in_exccode, in_wr, in_regwrite, in_ctrl, in_tnew, in_data,
    input  out_valid, out_pc, out_bd, out_exccode, out_wr, out_regwrite, out_ctrl, out_tnew, out_data
  );

  modport slave (
    input  req_i, flush_i, stall_i,
    input  in_valid, in_pc, in_bd, in_exccode, in_wr, in_regwrite, in_ctrl, in_tnew, in_data,
    output out_valid, out_pc, out_bd, out_exccode, out_wr, out_regwrite, out_ctrl, out_tnew, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core (F/D, D/E, E/M, M/W).
// Adds hold (stall), bubble insertion (flush), exception bubble (req) and a
// saturating Tnew decrement on top of a plain register slice.
// Ports:
//   clk   - clock, all updates on posedge
//   reset - synchronous, active-high; loads RESET_PC, clears everything else
//   bus   - pipe_stage_reg_if.slave: controls, in_* slot, registered out_* slot
// Priority: reset > req_i > flush_i > stall_i > load. Every output is a flop.
module pipe_stage_reg #(
  parameter int unsigned        N_DATA   = 4,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        CTRL_W   = 8,
  parameter int unsigned        TNEW_W   = 3,
  parameter int unsigned        EXC_W    = 5,
  parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(32'h0000_3000),
  parameter logic [DATA_W-1:0]  EXC_PC   = DATA_W'(32'h0000_4180)
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   bus
);
  localparam int unsigned PAYLOAD_W = N_DATA * DATA_W;
  localparam int unsigned WR_W      = 5;

  logic                 valid_q,    valid_d;
  logic [DATA_W-1:0]    pc_q,       pc_d;
  logic                 bd_q,       bd_d;
  logic [EXC_W-1:0]     exccode_q,  exccode_d;
  logic [WR_W-1:0]      wr_q,       wr_d;
  logic                 regwrite_q, regwrite_d;
  logic [CTRL_W-1:0]    ctrl_q,     ctrl_d;
  logic [TNEW_W-1:0]    tnew_q,     tnew_d;
  logic [PAYLOAD_W-1:0] data_q,     data_d;

  // State register; reset wins over everything, including a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      wr_q       <= '0;
      regwrite_q <= 1'b0;
      ctrl_q     <= '0;
      tnew_q     <= '0;
      data_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      wr_q       <= wr_d;
      regwrite_q <= regwrite_d;
      ctrl_q     <= ctrl_d;
      tnew_q     <= tnew_d;
      data_q     <= data_d;
    end
  end

  // Next-state selection; the default (hold) is the stall case.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    wr_d       = wr_q;
    regwrite_d = regwrite_q;
    ctrl_d     = ctrl_q;
    tnew_d     = tnew_q;
    data_d     = data_q;

    if (bus.req_i) begin
      // Exception bubble: redirect to the handler, drop the slot entirely.
      valid_d    = 1'b0;
      pc_d       = EXC_PC;
      bd_d       = 1'b0;
      exccode_d  = '0;
      wr_d       = '0;
      regwrite_d = 1'b0;
      ctrl_d     = '0;
      tnew_d     = '0;
      data_d     = '0;
    end else if (bus.flush_i) begin
      // Bubble keeps PC/BD so CP0 still sees the right macroscopic PC.
      valid_d    = 1'b0;
      pc_d       = bus.in_pc;
      bd_d       = bus.in_bd;
      exccode_d  = '0;
      wr_d       = '0;
      regwrite_d = 1'b0;
      ctrl_d     = '0;
      tnew_d     = '0;
      data_d     = '0;
    end else if (!bus.stall_i) begin
      valid_d    = bus.in_valid;
      pc_d       = bus.in_pc;
      bd_d       = bus.in_bd;
      exccode_d  = bus.in_exccode;
      // Hide the destination of non-writing instructions from forwarding.
      wr_d       = bus.in_regwrite ? bus.in_wr : WR_W'(0);
      regwrite_d = bus.in_regwrite & bus.in_valid;
      ctrl_d     = bus.in_ctrl;
      // Saturating decrement: Tnew never wraps back to all-ones.
      tnew_d     = (bus.in_tnew == '0) ? TNEW_W'(0) : bus.in_tnew - TNEW_W'(1);
      data_d     = bus.in_data;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_bd       = bd_q;
  assign bus.out_exccode  = exccode_q;
  assign bus.out_wr       = wr_q;
  assign bus.out_regwrite = regwrite_q;
  assign bus.out_ctrl     = ctrl_q;
  assign bus.out_tnew     = tnew_q;
  assign bus.out_data     = data_q;
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core. One instance serves each boundary (F/D, D/E, E/M, M/W).
- Adds four things the fixed per-stage registers lack: stall (hold), flush (bubble insertion), exception-request flush, and automatic saturating Tnew decrement.
- Carries the macroscopic PC, delay-slot flag and exception code so the CP0 logic sees correct values after bubbles.

Parameters:
- N_DATA, 4, number of DATA_W-bit payload channels (e.g. AO, DR, MDU_out, pc+8).
- DATA_W, 32, width of each payload channel and of the PC.
- CTRL_W, 8, width of the opaque control bus (MemtoReg, ALU op, etc.).
- TNEW_W, 3, width of the Tnew field.
- EXC_W, 5, width of the exception-code field.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, PC value loaded on exception request.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  1  exception/interrupt request; flush the stage to an exception bubble.
- flush_i  in  1  insert a bubble (hazard stall upstream).
- stall_i  in  1  hold the current contents.
- in_valid  in  1  the incoming slot holds a real instruction.
- in_pc  in  DATA_W  PC of the incoming instruction.
- in_bd  in  1  the incoming instruction is in a branch delay slot.
- in_exccode  in  EXC_W  exception code accumulated so far (0 = none).
- in_wr  in  5  destination register.
- in_regwrite  in  1  register write enable.
- in_ctrl  in  CTRL_W  control bus.
- in_tnew  in  TNEW_W  Tnew in the sending stage.
- in_data  in  N_DATA*DATA_W  flattened payload; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid, out_pc, out_bd, out_exccode, out_wr, out_regwrite, out_ctrl, out_data  out  same widths as the matching inputs  registered copies.
- out_tnew  out  TNEW_W  registered, decremented Tnew.

Behaviour:
- All state updates on posedge clk. Outputs are driven directly from registers; no combinational input-to-output path.
- Priority, highest first: reset > req_i > flush_i > stall_i > load.
- reset:
  - out_pc = RESET_PC.
  - All other outputs = 0, including out_valid, out_bd, out_exccode, out_wr, out_regwrite, out_ctrl, out_tnew and out_data.
- req_i:
  - Same as reset, except out_pc = EXC_PC.
- flush_i (bubble):
  - out_pc = in_pc and out_bd = in_bd, so the macroscopic PC/BD seen by CP0 stays correct behind a stall.
  - out_valid = 0; out_exccode, out_wr, out_regwrite, out_ctrl, out_tnew, out_data = 0.
- stall_i:
  - Every register holds its value; out_tnew is not decremented.
- load (none of the above asserted):
  - Every output takes its input.
  - out_tnew = (in_tnew == 0) ? 0 : in_tnew - 1. Saturating; it never wraps to all-ones.
  - out_wr = in_regwrite ? in_wr : 5'd0. A non-writing instruction never exposes a destination register to forwarding.
  - out_regwrite = in_regwrite & in_valid. An invalid slot never writes.
- Simultaneous events:
  - flush_i with stall_i: flush wins, giving a bubble.
  - req_i with anything: the exception bubble wins.
  - reset during a stall: the register still resets.
- Latency is exactly 1 cycle from input to output when loading.
- Throughput is 1 instruction per cycle when stall_i = 0.
- The payload is opaque. No channel is interpreted, and N_DATA = 1 must elaborate.

Test Plan:
1. Reset then load: assert reset 1 cycle, then load in_pc=0x3004, in_tnew=2, in_regwrite=1, in_valid=1, in_wr=8, data ch0=0xDEADBEEF.
   - During reset: out_pc=0x3000, all other outputs 0.
   - Next cycle: out_pc=0x3004, out_tnew=1, out_wr=8, ch0=0xDEADBEEF.
2. Tnew saturation: load in_tnew=0 -> out_tnew=0 (not 7). Load in_tnew=1 -> out_tnew=0.
3. Stall hold: load pc=0x3010, then assert stall_i for 3 cycles while the inputs change -> all outputs stay at the pc=0x3010 values; out_tnew does not decrement.
4. Flush with stall: assert flush_i and stall_i together with in_pc=0x3020, in_bd=1 -> out_pc=0x3020, out_bd=1, out_valid=0, out_regwrite=0, out_wr=0, out_data=0.
5. Exception: assert req_i with flush_i=1 and stall_i=1 -> out_pc=0x4180, everything else 0. Following load cycle with in_pc=0x4180 -> normal transfer resumes.
6. Write gating:
   - in_regwrite=0, in_wr=31 -> out_wr=0.
   - in_valid=0, in_regwrite=1 -> out_regwrite=0.
   - Repeat with N_DATA=1 and N_DATA=6 to confirm elaboration and channel ordering.
